nrng: RTL and testbench

NRNG -- requirements
Module: nrng

---
 rtl/nrng_if.sv | 13 +
 rtl/nrng.sv | 131 +++++++++++++
 tb/tb_nrng.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/nrng_if.sv
// Valid/ready/data channel shared by the nrng configuration input and point output.
interface dti #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport producer (output valid, output data, input  ready);
    modport consumer (input  valid, input  data, output ready);
    modport master   (output valid, output data, input  ready);
    modport slave    (input  valid, input  data, output ready);
endinterface

// File: rtl/nrng.sv
// Nested range generator: walks an NDIM-deep {start, stop, incr} range, dim 0 fastest,
// one point per output handshake; the config handshake completes on the final point.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no point emitted yet; outputs show the cfg start fields
//   ST_BUSY | mid-range; outputs show the per-dim counters
module nrng #(
    parameter int NDIM      = 2,
    parameter int W         = 16,
    parameter int SIGNED    = 0,
    parameter int INCLUSIVE = 0
) (
    input  logic clk,
    input  logic rst,
    dti.consumer cfg,
    dti.producer dout
);
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      start_f [NDIM];
    logic [W-1:0]      stop_f  [NDIM];
    logic [W-1:0]      incr_f  [NDIM];
    logic [W-1:0]      value   [NDIM];
    logic [W-1:0]      cnt_q   [NDIM];
    logic [W-1:0]      cnt_d   [NDIM];
    logic [W:0]        next_v  [NDIM];
    logic [NDIM-1:0]   last_v, carry, eot;
    logic [NDIM*W-1:0] value_flat;
    logic [W:0]        stop_x;
    logic              sgn_v, sgn_i, sgn_s, gt_v, eq_v, acc;
    logic              hs, fin;

    if (NDIM < 1 || NDIM > 4) begin : g_ndim_err
        $error("nrng: NDIM must be 1..4");
    end
    if ($bits(cfg.data) != NDIM*3*W) begin : g_cfg_width_err
        $error("nrng: cfg data width must be NDIM*3*W");
    end
    if ($bits(dout.data) != NDIM*W + NDIM) begin : g_dout_width_err
        $error("nrng: dout data width must be NDIM*W+NDIM");
    end

    always_comb begin : field_decode
        value_flat = '0;
        for (int k = 0; k < NDIM; k++) begin
            start_f[k] = cfg.data[3*W*k       +: W];
            stop_f[k]  = cfg.data[3*W*k + W   +: W];
            incr_f[k]  = cfg.data[3*W*k + 2*W +: W];
            value[k]   = (state_q == ST_BUSY) ? cnt_q[k] : start_f[k];
            value_flat[W*k +: W] = value[k];
        end
    end

    // The extra bit keeps an overflowing step out of range instead of wrapping back in.
    always_comb begin : step_compare
        stop_x = '0;
        sgn_v  = 1'b0;
        sgn_i  = 1'b0;
        sgn_s  = 1'b0;
        gt_v   = 1'b0;
        eq_v   = 1'b0;
        last_v = '0;
        for (int k = 0; k < NDIM; k++) begin
            next_v[k] = '0;
            sgn_v = (SIGNED != 0) && value[k][W-1];
            sgn_i = (SIGNED != 0) && incr_f[k][W-1];
            sgn_s = (SIGNED != 0) && stop_f[k][W-1];
            next_v[k] = {sgn_v, value[k]} + {sgn_i, incr_f[k]};
            stop_x    = {sgn_s, stop_f[k]};
            gt_v = (SIGNED != 0) ? ($signed(next_v[k]) > $signed(stop_x)) : (next_v[k] > stop_x);
            eq_v = (next_v[k] == stop_x);
            if (incr_f[k] == '0)
                last_v[k] = 1'b1;
            else if (sgn_i)
                last_v[k] = (INCLUSIVE != 0) ? !(gt_v || eq_v) : !gt_v;
            else
                last_v[k] = (INCLUSIVE != 0) ? gt_v : (gt_v || eq_v);
        end
    end

    always_comb begin : eot_chain
        acc   = 1'b1;
        carry = '0;
        eot   = '0;
        for (int k = 0; k < NDIM; k++) begin
            carry[k] = acc;
            acc      = acc & last_v[k];
            eot[k]   = acc;
        end
    end

    assign hs         = cfg.valid & dout.ready;
    assign fin        = hs & eot[NDIM-1];
    assign dout.valid = cfg.valid;
    assign dout.data  = {eot, value_flat};
    assign cfg.ready  = fin;

    always_comb begin : next_state
        state_d = state_q;
        for (int k = 0; k < NDIM; k++) cnt_d[k] = cnt_q[k];
        if (hs) begin
            if (fin) begin
                state_d = ST_IDLE;
                for (int k = 0; k < NDIM; k++) cnt_d[k] = start_f[k];
            end else begin
                state_d = ST_BUSY;
                // Holding copies value, not cnt_q, so leaving idle latches the start fields.
                for (int k = 0; k < NDIM; k++) begin
                    if (eot[k])
                        cnt_d[k] = start_f[k];
                    else if (carry[k] && !last_v[k])
                        cnt_d[k] = next_v[k][W-1:0];
                    else
                        cnt_d[k] = value[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            for (int k = 0; k < NDIM; k++) cnt_q[k] <= '0;
        end else begin
            state_q <= state_d;
            for (int k = 0; k < NDIM; k++) cnt_q[k] <= cnt_d[k];
        end
    end
endmodule

// File: tb/tb_nrng.sv
// Scoreboard bench for nrng: an unsigned/exclusive and a signed/inclusive instance,
// expected points computed from per-dim value lists and their row-major product.
module tb_nrng;
    localparam int W  = 8;
    localparam int ND = 2;
    localparam int CW = ND*3*W;
    localparam int DW = ND*W + ND;

    typedef struct {
        int            sel;
        logic [DW-1:0] data;
        logic          fin;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cv [2];
    logic [CW-1:0] cd [2];
    logic          rd [2];
    logic          cr [2];
    logic          dv [2];
    logic [DW-1:0] dd [2];

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    dti #(.WIDTH(CW)) cfg0 ();
    dti #(.WIDTH(DW)) dout0 ();
    dti #(.WIDTH(CW)) cfg1 ();
    dti #(.WIDTH(DW)) dout1 ();

    assign cfg0.valid  = cv[0];
    assign cfg0.data   = cd[0];
    assign dout0.ready = rd[0];
    assign cr[0]       = cfg0.ready;
    assign dv[0]       = dout0.valid;
    assign dd[0]       = dout0.data;
    assign cfg1.valid  = cv[1];
    assign cfg1.data   = cd[1];
    assign dout1.ready = rd[1];
    assign cr[1]       = cfg1.ready;
    assign dv[1]       = dout1.valid;
    assign dd[1]       = dout1.data;

    nrng #(.NDIM(ND), .W(W), .SIGNED(0), .INCLUSIVE(0)) dut0 (
        .clk(clk), .rst(rst), .cfg(cfg0), .dout(dout0)
    );
    nrng #(.NDIM(ND), .W(W), .SIGNED(1), .INCLUSIVE(1)) dut1 (
        .clk(clk), .rst(rst), .cfg(cfg1), .dout(dout1)
    );

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (dv[i] !== cv[i]) begin
                fails++;
                $display("FAIL valid_follow inst=%0d got=%b exp=%b", i, dv[i], cv[i]);
            end
            if (dv[i] === 1'b1 && rd[i] === 1'b1) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL extra_point inst=%0d got=%h exp=none", i, dd[i]);
                end else begin
                    e = sb.pop_front();
                    if (e.sel != i || dd[i] !== e.data || cr[i] !== e.fin) begin
                        fails++;
                        $display("FAIL point inst=%0d got data=%h cfg_ready=%b exp inst=%0d data=%h cfg_ready=%b",
                                 i, dd[i], cr[i], e.sel, e.data, e.fin);
                    end
                end
            end else begin
                tests++;
                if (cr[i] !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_cfg_ready inst=%0d got=%b exp=0", i, cr[i]);
                end
            end
        end
    end

    function automatic logic [23:0] fld(input int st, input int sp, input int inc);
        return {inc[7:0], sp[7:0], st[7:0]};
    endfunction

    // Expected points: per-dim value lists from the range rules, then row-major product.
    task automatic push_expect(input int sel, input logic [CW-1:0] c, output int n);
        int   dvq[2][$];
        int   s, p, inc, v, nx, v0, v1;
        bit   sgn, stop_now, e0, e1;
        logic [7:0] fs, fp, fi;
        exp_t e;
        sgn = (sel == 1);
        n   = 0;
        for (int k = 0; k < 2; k++) begin
            fs  = c[24*k +: 8];
            fp  = c[24*k + 8 +: 8];
            fi  = c[24*k + 16 +: 8];
            s   = sgn ? int'($signed(fs)) : int'(fs);
            p   = sgn ? int'($signed(fp)) : int'(fp);
            inc = sgn ? int'($signed(fi)) : int'(fi);
            v   = s;
            dvq[k].delete();
            forever begin
                dvq[k].push_back(v);
                if (inc == 0 || dvq[k].size() > 300) break;
                nx = v + inc;
                if (inc > 0) stop_now = sgn ? (nx > p) : (nx >= p);
                else         stop_now = sgn ? (nx < p) : (nx <= p);
                if (stop_now) break;
                v = nx;
            end
        end
        for (int a = 0; a < dvq[1].size(); a++) begin
            for (int b = 0; b < dvq[0].size(); b++) begin
                v0 = dvq[0][b];
                v1 = dvq[1][a];
                e0 = (b == dvq[0].size() - 1);
                e1 = e0 && (a == dvq[1].size() - 1);
                e.sel  = sel;
                e.data = {e1, e0, v1[7:0], v0[7:0]};
                e.fin  = e1;
                sb.push_back(e);
                n++;
            end
        end
    endtask

    // rmode: 0 ready high, 1 ready toggling 1010..., 2 random ready.
    task automatic run_txn(input int sel, input logic [CW-1:0] c, input int rmode, input int rst_after);
        int n, budget, tog;
        bit did_rst;
        did_rst = 0;
        tog     = 0;
        push_expect(sel, c, n);
        budget = 4*n + 20;
        @(posedge clk); #1;
        cd[sel] = c;
        cv[sel] = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (sb.size() == 0) break;
            if (!did_rst && rst_after >= 0 && (n - sb.size()) == rst_after) begin
                rd[sel] = 1'b0;
                rst     = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                sb.delete();
                push_expect(sel, c, n);
                did_rst = 1;
            end
            case (rmode)
                0:       rd[sel] = 1'b1;
                1:       rd[sel] = ((tog % 2) == 0);
                default: rd[sel] = ($urandom_range(0, 3) != 0);
            endcase
            tog++;
            @(posedge clk); #1;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL txn_timeout inst=%0d got=%0d points left exp=0", sel, sb.size());
            sb.delete();
        end
        cv[sel] = 1'b0;
        rd[sel] = 1'b0;
    endtask

    task automatic rand_txn(input int sel);
        int st, sp, inc, span;
        logic [CW-1:0] c;
        for (int k = 0; k < 2; k++) begin
            if (sel == 0) begin
                st  = $urandom_range(0, 255);
                inc = (k == 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(10, 60))
                                                          : int'($urandom_range(0, 9));
                sp  = (st + $urandom_range(0, 24)) & 255;
            end else begin
                st   = int'($urandom_range(0, 255)) - 128;
                inc  = int'($urandom_range(0, 16)) - 8;
                span = $urandom_range(0, 20);
                sp   = (inc < 0) ? st - span : st + span;
            end
            c[24*k +: 24] = fld(st, sp, inc);
        end
        run_txn(sel, c, 2, -1);
    endtask

    localparam logic [CW-1:0] CFG_A = {24'h010c0a, 24'h010300};

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cv[i] = 1'b0;
            cd[i] = '0;
            rd[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        run_txn(0, CFG_A, 0, -1);
        run_txn(0, CFG_A, 1, -1);
        run_txn(1, {fld(0, 0, 0), fld(3, -3, -2)}, 0, -1);
        run_txn(0, {fld(0, 0, 0), fld(250, 255, 4)}, 2, -1);
        run_txn(0, {fld(0, 2, 1), fld(5, 5, 1)}, 0, -1);
        run_txn(0, {fld(0, 2, 1), fld(7, 9, 0)}, 1, -1);
        run_txn(0, {fld(0, 2, 1), fld(9, 4, 1)}, 0, -1);
        run_txn(1, {fld(-2, 2, 2), fld(120, 127, 3)}, 2, -1);
        run_txn(1, {fld(1, 1, 1), fld(-5, -4, -1)}, 0, -1);
        run_txn(0, CFG_A, 0, 2);
        run_txn(0, CFG_A, 2, -1);
        for (int r = 0; r < 12; r++) begin
            rand_txn(0);
            rand_txn(1);
        end
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
